// File: rtl/vending_machine.sv
// vending_machine: two-product coin vending controller with continue-buying window and registered refund
// Ports: clk/rst (async active-high); coin_5, coin_10, select_mixue, select_starbucks,
//        cancel, confirm, continue_buying (1-cycle pulses); dispense_mixue, dispense_starbucks
//        (1-cycle pulses); change[5:0] (refund, nonzero only in the REFUND cycle).
module vending_machine #(
  parameter logic [5:0] PRICE_MIXUE = 6'd10,
  parameter logic [5:0] PRICE_STARBUCKS = 6'd25,
  parameter logic [5:0] MAX_CREDIT = 6'd60,
  parameter logic [3:0] CONT_TIMEOUT = 4'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_5,
  input  logic       coin_10,
  input  logic       select_mixue,
  input  logic       select_starbucks,
  input  logic       cancel,
  input  logic       confirm,
  input  logic       continue_buying,
  output logic       dispense_mixue,
  output logic       dispense_starbucks,
  output logic [5:0] change
);
  localparam logic [2:0] IDLE = 3'd0, COLLECT = 3'd1, SELECTED = 3'd2,
                         DISPENSE = 3'd3, WAIT_CONT = 3'd4, REFUND = 3'd5;
  localparam logic [1:0] NONE = 2'd0, MIXUE = 2'd1, STARBUCKS = 2'd2;
  logic [2:0] state;
  logic [1:0] sel;
  logic [5:0] balance, price;
  logic [3:0] cnt;
  logic [6:0] sum;
  logic coin_ok, any_sel;
  // sum is one bit wider than balance so the ceiling test never wraps
  always_comb begin
    sum = {1'b0, balance} + (coin_5 ? 7'd5 : 7'd0) + (coin_10 ? 7'd10 : 7'd0);
    coin_ok = (coin_5 | coin_10) && sum <= {1'b0, MAX_CREDIT};
    price = sel == STARBUCKS ? PRICE_STARBUCKS : PRICE_MIXUE;
    any_sel = select_mixue | select_starbucks;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      sel <= NONE;
      balance <= '0;
      cnt <= '0;
      dispense_mixue <= 1'b0;
      dispense_starbucks <= 1'b0;
      change <= '0;
    end else begin
      dispense_mixue <= 1'b0;
      dispense_starbucks <= 1'b0;
      change <= '0;
      case (state)
        IDLE:
          if (coin_ok) begin
            balance <= sum[5:0];
            state <= COLLECT;
          end
        COLLECT:
          if (cancel) begin
            change <= balance;
            state <= REFUND;
          end else if (any_sel) begin
            sel <= select_mixue ? MIXUE : STARBUCKS;
            state <= SELECTED;
          end else if (coin_ok) balance <= sum[5:0];
        SELECTED:
          if (cancel) begin
            change <= balance;
            state <= REFUND;
          end else if (confirm) begin
            // dispense pulse is registered on entry so it coincides with the DISPENSE cycle
            if (balance >= price) begin
              dispense_mixue <= sel == MIXUE;
              dispense_starbucks <= sel == STARBUCKS;
              state <= DISPENSE;
            end
          end else if (any_sel) sel <= select_mixue ? MIXUE : STARBUCKS;
          else if (coin_ok) balance <= sum[5:0];
        DISPENSE: begin
          balance <= balance - price;
          sel <= NONE;
          cnt <= '0;
          state <= WAIT_CONT;
        end
        WAIT_CONT:
          if (cancel) begin
            change <= balance;
            state <= REFUND;
          end else if (continue_buying) state <= COLLECT;
          else if (cnt == CONT_TIMEOUT - 4'd1) begin
            change <= balance;
            state <= REFUND;
          end else cnt <= cnt + 4'd1;
        REFUND: begin
          balance <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_vending_machine.sv
// tb_vending_machine: directed scoreboard bench for vending_machine
module tb_vending_machine;
  logic clk = 1'b0, rst = 1'b1;
  logic coin_5 = 1'b0, coin_10 = 1'b0, select_mixue = 1'b0, select_starbucks = 1'b0;
  logic cancel = 1'b0, confirm = 1'b0, continue_buying = 1'b0;
  logic dispense_mixue, dispense_starbucks;
  logic [5:0] change;
  logic [7:0] exp_q[$];
  int compared = 0, mismatched = 0;
  localparam logic [6:0] NOP = 7'h00, C5 = 7'h40, C10 = 7'h20, SM = 7'h10, SS = 7'h08,
                         CAN = 7'h04, CONF = 7'h02, CONT = 7'h01;
  localparam logic [7:0] Z = 8'h00, DM = 8'h80, DS = 8'h40;
  vending_machine dut (
    .clk(clk), .rst(rst), .coin_5(coin_5), .coin_10(coin_10),
    .select_mixue(select_mixue), .select_starbucks(select_starbucks),
    .cancel(cancel), .confirm(confirm), .continue_buying(continue_buying),
    .dispense_mixue(dispense_mixue), .dispense_starbucks(dispense_starbucks), .change(change)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag);
    logic [7:0] got, e;
    got = {dispense_mixue, dispense_starbucks, change};
    e = exp_q.pop_front();
    compared++;
    assert (got === e) else begin
      mismatched++;
      $error("FAIL %s: observed dm=%b ds=%b change=%0d, expected dm=%b ds=%b change=%0d",
             tag, got[7], got[6], got[5:0], e[7], e[6], e[5:0]);
    end
  endtask
  task automatic step(input string tag, input logic [6:0] in, input logic [7:0] e);
    {coin_5, coin_10, select_mixue, select_starbucks, cancel, confirm, continue_buying} = in;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    {coin_5, coin_10, select_mixue, select_starbucks, cancel, confirm, continue_buying} = NOP;
    check(tag);
  endtask
  task automatic idle_steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, NOP, Z);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(Z);
    check("reset_outputs");
    rst = 1'b0;
    // 1: single Mixue purchase, then continue with zero balance
    step("t1_coin", C10, Z);
    step("t1_sel", SM, Z);
    step("t1_disp", CONF, DM);
    step("t1_disp_one_cycle", NOP, Z);
    step("t1_cont", CONT, Z);
    step("t1_cancel_zero", CAN, Z);
    step("t1_idle", NOP, Z);
    // 2: Starbucks purchase, timeout refund of 5 after exactly 4 WAIT_CONT cycles
    repeat (3) step("t2_coin", C10, Z);
    step("t2_sel", SS, Z);
    step("t2_disp", CONF, DS);
    idle_steps("t2_wait", 4);
    step("t2_refund", NOP, 8'd5);
    step("t2_refund_clear", NOP, Z);
    // 3: insufficient credit stays SELECTED, cancel refunds
    step("t3_coin", C5, Z);
    step("t3_sel", SS, Z);
    step("t3_confirm_short", CONF, Z);
    step("t3_cancel", CAN, 8'd5);
    step("t3_clear", NOP, Z);
    // 4: credit ceiling at 60, extra coins ignored
    repeat (6) step("t4_coin", C10, Z);
    step("t4_coin_over", C10, Z);
    step("t4_coin5_over", C5, Z);
    step("t4_cancel", CAN, 8'd60);
    step("t4_clear", NOP, Z);
    // 5: both coins in one cycle credit 15
    step("t5_both_coins", C5 | C10, Z);
    step("t5_sel", SM, Z);
    step("t5_disp", CONF, DM);
    step("t5_wait", NOP, Z);
    step("t5_cancel", CAN, 8'd5);
    step("t5_clear", NOP, Z);
    // priority: both selects pick Mixue; cancel beats confirm; IDLE ignores cancel
    step("p_idle_cancel", CAN, Z);
    step("p_coin", C10, Z);
    step("p_both_sel", SM | SS, Z);
    step("p_cancel_over_confirm", CAN | CONF, 8'd10);
    step("p_clear", NOP, Z);
    step("p_coin2", C10, Z);
    step("p_both_sel2", SM | SS, Z);
    step("p_mixue_wins", CONF, DM);
    step("p_cont", NOP, Z);
    step("p_continue", CONT, Z);
    step("p_coin_collect", C5, Z);
    step("p_cancel_collect", CAN, 8'd5);
    step("p_clear2", NOP, Z);
    // 6: async reset mid-SELECTED with credit 20 discards credit
    step("t6_coin_a", C10, Z);
    step("t6_coin_b", C10, Z);
    step("t6_sel", SM, Z);
    #2 rst = 1'b1;
    #1 exp_q.push_back(Z);
    check("t6_rst_immediate");
    @(posedge clk);
    #1 rst = 1'b0;
    step("t6_idle_cancel", CAN, Z);
    step("t6_coin", C5, Z);
    step("t6_cancel", CAN, 8'd5);
    step("t6_clear", NOP, Z);
    // async reset cuts a dispense pulse immediately
    step("r_coin", C10, Z);
    step("r_sel", SS | SM, Z);
    step("r_disp", CONF, DM);
    #2 rst = 1'b1;
    #1 exp_q.push_back(Z);
    check("r_rst_cuts_pulse");
    @(posedge clk);
    #1 rst = 1'b0;
    step("r_after_cancel", CAN, Z);
    step("r_after_idle", NOP, Z);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
